// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronising reference LFSR with lock detection and BER counters.
// Optional build macro LFSR_CHK_CLR_EN adds a synchronous counter-clear input 'clr'.
module lfsr_checker #(
  parameter int LFSR_WID   = 22,
  parameter int TAP_A      = 22,
  parameter int TAP_B      = 21,
  parameter int VERIFY_LEN = 64,
  parameter int WIN_LEN    = 256,
  parameter int THRESH     = 32,
  parameter int CNT_WID    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               bit_in,
`ifdef LFSR_CHK_CLR_EN
  input  logic               clr,
`endif
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_WID-1:0] bit_cnt,
  output logic [CNT_WID-1:0] err_cnt
);

  localparam int FW = $clog2(LFSR_WID + 1);
  localparam int MW = $clog2(VERIFY_LEN + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(THRESH + 1);

  localparam logic [FW-1:0]      FILL_LAST  = FW'(LFSR_WID - 1);
  localparam logic [FW-1:0]      FILL_ONE   = FW'(1);
  localparam logic [MW-1:0]      MATCH_LAST = MW'(VERIFY_LEN - 1);
  localparam logic [MW-1:0]      MATCH_ONE  = MW'(1);
  localparam logic [WW-1:0]      WIN_LAST   = WW'(WIN_LEN - 1);
  localparam logic [WW-1:0]      WIN_ONE    = WW'(1);
  localparam logic [EW-1:0]      ERR_LAST   = EW'(THRESH - 1);
  localparam logic [EW-1:0]      ERR_ONE    = EW'(1);
  localparam logic [CNT_WID-1:0] CNT_MAX    = {CNT_WID{1'b1}};
  localparam logic [CNT_WID-1:0] CNT_ONE    = CNT_WID'(1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LFSR_WID-1:0]   sr_q, sr_d;
  logic [FW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d;
  logic [WW-1:0]         win_cnt_q, win_cnt_d;
  logic [EW-1:0]         win_err_q, win_err_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [CNT_WID-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_WID-1:0]    err_cnt_q, err_cnt_d;

  logic pred_s;
  logic mis_s;
  logic clr_s;

  assign pred_s = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
  assign mis_s  = bit_in ^ pred_s;

`ifdef LFSR_CHK_CLR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // Sync state machine: hunt fills sr from the line, check/lock free-run the reference.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    if (en) begin
      case (state_q)
        ST_HUNT: begin
          sr_d = {sr_q[LFSR_WID-2:0], bit_in};
          if (fill_cnt_q == FILL_LAST) begin
            fill_cnt_d = '0;
            // An all-zero seed would lock the reference at zero forever.
            if (sr_d == '0) begin
              state_d = ST_HUNT;
            end else begin
              state_d     = ST_CHECK;
              match_cnt_d = '0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_ONE;
          end
        end
        ST_CHECK: begin
          sr_d = {sr_q[LFSR_WID-2:0], pred_s};
          if (mis_s) begin
            state_d    = ST_HUNT;
            fill_cnt_d = '0;
          end else if (match_cnt_q == MATCH_LAST) begin
            state_d     = ST_LOCK;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_ONE;
          end
        end
        ST_LOCK: begin
          sr_d = {sr_q[LFSR_WID-2:0], pred_s};
          // Threshold check outranks the window boundary on the same bit.
          if (mis_s && (win_err_q == ERR_LAST)) begin
            state_d    = ST_HUNT;
            fill_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            win_err_d = mis_s ? (win_err_q + ERR_ONE) : win_err_q;
          end
        end
        default: begin
          state_d    = ST_HUNT;
          fill_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCK);
  end

  // Saturating BER counters and error strobe, with optional clear taking priority.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (clr_s) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (en && (state_q == ST_LOCK)) begin
      bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : (bit_cnt_q + CNT_ONE);
      if (mis_s) begin
        err_cnt_d   = (err_cnt_q == CNT_MAX) ? err_cnt_q : (err_cnt_q + CNT_ONE);
        err_pulse_d = 1'b1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: 4-bit x^4+x^3+1 generator stream, en every 4 clks, err_pulse scoreboard.
module tb_lfsr_checker;

  localparam int LW   = 4;
  localparam int TAPA = 4;
  localparam int TAPB = 3;
  localparam int VL   = 8;
  localparam int WL   = 256;
  localparam int TH   = 32;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          bit_in;
  logic          clr;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] gen_sr = 4'b1001;
  logic          exp_q[$];

  lfsr_checker #(
    .LFSR_WID(LW), .TAP_A(TAPA), .TAP_B(TAPB), .VERIFY_LEN(VL),
    .WIN_LEN(WL), .THRESH(TH), .CNT_WID(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .bit_in   (bit_in),
`ifdef LFSR_CHK_CLR_EN
    .clr      (clr),
`endif
    .locked   (locked),
    .err_pulse(err_pulse),
    .bit_cnt  (bit_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic gen_next();
    logic b;
    b      = gen_sr[TAPA-1] ^ gen_sr[TAPB-1];
    gen_sr = {gen_sr[LW-2:0], b};
    return b;
  endfunction

  // One enabled bit (optionally inverted) then three idle clocks; pops the expected err_pulse.
  task automatic send_bit(input logic flip, input logic exp_pulse);
    logic want;
    @(negedge clk);
    en     = 1'b1;
    bit_in = gen_next() ^ flip;
    exp_q.push_back(exp_pulse);
    @(negedge clk);
    en   = 1'b0;
    want = exp_q.pop_front();
    total++;
    if (err_pulse !== want) begin
      bad++;
      $display("FAIL err_pulse: got %b want %b", err_pulse, want);
    end
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse_width: got %b want 0", err_pulse);
    end
    @(negedge clk);
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    en     = 1'b0;
    bit_in = 1'b0;
    clr    = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({locked, err_pulse, bit_cnt, err_cnt} !== {2'b00, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_state: got %b/%b/%0d/%0d want 0/0/0/0", locked, err_pulse, bit_cnt, err_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    send_clean(11);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", locked); end
    send_clean(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_at_12: got %b want 1", locked); end
    send_clean(100);
    total++;
    if (bit_cnt !== 8'd100) begin bad++; $display("FAIL bit_cnt_100: got %0d want 100", bit_cnt); end
    total++;
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL err_cnt_clean: got %0d want 0", err_cnt); end
  endtask

  task automatic test_isolated();
    for (int i = 0; i < 100; i++) begin
      logic f;
      f = (i == 10) || (i == 40) || (i == 70);
      send_bit(f, f);
    end
    total++;
    if (err_cnt !== 8'd3) begin bad++; $display("FAIL iso_err_cnt: got %0d want 3", err_cnt); end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL iso_locked: got %b want 1", locked); end
    total++;
    if (bit_cnt !== 8'd200) begin bad++; $display("FAIL iso_bit_cnt: got %0d want 200", bit_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en     = 1'b1;
    bit_in = gen_next() ^ 1'b1;
    @(negedge clk);
    en = 1'b0;
    total++;
    if (err_pulse !== 1'b1) begin bad++; $display("FAIL pre_reset_pulse: got %b want 1", err_pulse); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({locked, err_pulse, bit_cnt, err_cnt} !== {2'b00, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset: got %b/%b/%0d/%0d want 0/0/0/0", locked, err_pulse, bit_cnt, err_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    send_clean(11);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", locked); end
    send_clean(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
  endtask

  task automatic test_burst();
    send_clean(5);
    for (int i = 0; i < 32; i++) begin
      send_bit(1'b1, 1'b1);
      if (i == 30) begin
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL burst_31_locked: got %b want 1", locked); end
      end
    end
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL burst_unlock: got %b want 0", locked); end
    total++;
    if (err_cnt !== 8'd32) begin bad++; $display("FAIL burst_err_cnt: got %0d want 32", err_cnt); end
    send_clean(11);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL burst_relock_early: got %b want 0", locked); end
    send_clean(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL burst_relock: got %b want 1", locked); end
    total++;
    if (bit_cnt !== 8'd37) begin bad++; $display("FAIL burst_bit_hold: got %0d want 37", bit_cnt); end
    send_clean(3);
    total++;
    if ({bit_cnt, err_cnt} !== {8'd40, 8'd32}) begin
      bad++;
      $display("FAIL burst_continue: got %0d/%0d want 40/32", bit_cnt, err_cnt);
    end
  endtask

  // 31 errors end on the last bit of window 1, 31 more open window 2: lock must survive.
  task automatic test_window();
    do_reset();
    send_clean(12);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL win_lock: got %b want 1", locked); end
    for (int i = 1; i <= 287; i++) begin
      logic f;
      f = (i >= 226);
      send_bit(f, f);
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL win_locked: got %b want 1", locked); end
    total++;
    if (err_cnt !== 8'd62) begin bad++; $display("FAIL win_err_cnt: got %0d want 62", err_cnt); end
    total++;
    if (bit_cnt !== 8'd255) begin bad++; $display("FAIL bit_cnt_sat: got %0d want 255", bit_cnt); end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en     = 1'b1;
      bit_in = 1'b0;
      @(negedge clk);
      en = 1'b0;
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL zero_locked: got %b want 0", locked); end
      repeat (2) @(negedge clk);
    end
    total++;
    if ({bit_cnt, err_cnt} !== {8'd0, 8'd0}) begin
      bad++;
      $display("FAIL zero_counters: got %0d/%0d want 0/0", bit_cnt, err_cnt);
    end
    send_clean(12);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL zero_recover: got %b want 1", locked); end
  endtask

`ifdef LFSR_CHK_CLR_EN
  task automatic test_clr();
    for (int i = 0; i < 20; i++) begin
      logic f;
      f = ((i % 4) == 1);
      send_bit(f, f);
    end
    total++;
    if (err_cnt !== 8'd5) begin bad++; $display("FAIL clr_pre_err: got %0d want 5", err_cnt); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if ({locked, bit_cnt, err_cnt} !== {1'b1, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL clr: got %b/%0d/%0d want 1/0/0", locked, bit_cnt, err_cnt);
    end
    @(negedge clk);
    clr    = 1'b1;
    en     = 1'b1;
    bit_in = gen_next() ^ 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b0;
    total++;
    if ({err_pulse, bit_cnt, err_cnt} !== {1'b0, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL clr_wins: got %b/%0d/%0d want 0/0/0", err_pulse, bit_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_isolated();
    test_async_reset();
    test_burst();
    test_window();
    test_all_zero();
`ifdef LFSR_CHK_CLR_EN
    test_clr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side PRBS checker: consumes the serial bit stream produced by the LFSR pattern generator (one bit per clock enable), self-synchronises a local reference LFSR, and counts bit errors.
- Sits after the decision/slicer stage; runs on the system clock with the sample/symbol enable from clk_en.
- Provides lock status and BER counters for measuring link error against the transmitted LFSR pattern.

Parameters:
- LFSR_WID, 22, shift-register length (polynomial degree).
- TAP_A, 22, first feedback tap (1-based position).
- TAP_B, 21, second feedback tap (1-based position, TAP_B < TAP_A <= LFSR_WID).
- VERIFY_LEN, 64, consecutive matching bits required in CHECK before declaring lock.
- WIN_LEN, 256, window length in bits for loss-of-lock monitoring.
- THRESH, 32, mismatches within one window that force loss of lock (THRESH <= WIN_LEN).
- CNT_WID, 32, width of bit_cnt and err_cnt.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  bit-valid strobe (sam_clk_en/sym_clk_en); one-clk pulse.
- bit_in  in  1  received data bit, valid when en=1.
- locked  out  1  high while in LOCK state.
- err_pulse  out  1  one-clk pulse, cycle after a mismatching bit while locked.
- bit_cnt  out  CNT_WID  bits checked while locked, saturating.
- err_cnt  out  CNT_WID  mismatches while locked, saturating.

Behaviour:
- Reset (reset=0, async): state=HUNT; sr, fill_cnt, match_cnt, win_cnt, win_err=0; locked=0, err_pulse=0, bit_cnt=0, err_cnt=0.
- All state advances only on clk edges with en=1; en=0 holds everything. Exception: err_pulse returns to 0 on the next clk.
- sr[0] holds the newest bit. Predicted bit is p = sr[TAP_A-1] ^ sr[TAP_B-1].
- HUNT: shift bit_in into sr; fill_cnt++. When LFSR_WID bits have been loaded, evaluate the resulting sr:
  - sr all zero: clear fill_cnt, stay in HUNT (lockup guard).
  - otherwise: go to CHECK with match_cnt=0.
- CHECK: shift p (not bit_in) into sr, so the reference runs free.
  - bit_in==p: match_cnt++; on the VERIFY_LEN-th match go to LOCK with win_cnt=win_err=0.
  - any mismatch: go to HUNT with fill_cnt=0.
  - bit_cnt and err_cnt are not updated in CHECK.
- LOCK: shift p into sr; bit_cnt++.
  - Mismatch: err_cnt++, err_pulse=1 next cycle, win_err++.
  - win_cnt++; when win_cnt completes WIN_LEN bits, clear win_cnt and win_err. An error on the final bit counts before the clear.
  - If win_err reaches THRESH: go to HUNT, fill_cnt=0. locked falls on the same edge the state changes.
- locked is registered: high exactly while state==LOCK.
- Counters saturate at 2^CNT_WID-1 and never wrap. Both hold their value through loss of lock; only reset clears them.
- Simultaneous window-end and THRESH reached: THRESH takes priority, go to HUNT.
- Async reset asserted mid-stream: all outputs return to reset values immediately.

Optional Feature:
- Macro LFSR_CHK_CLR_EN.
- Defined: adds input port clr (1 bit, synchronous, active-high). clr=1 zeros bit_cnt, err_cnt and err_pulse on the next clk, regardless of en. State, sr and locked are unaffected. If clr and a counted bit coincide, the clear wins and that bit is dropped.
- Not defined: no clr port; counters clear only on reset.

Test Plan:
- LFSR_WID=4, TAP 4/3, VERIFY_LEN=8. Error-free generator stream (period 15), en every 4 clks -> locked rises after 4+8=12 enabled bits; err_cnt=0; bit_cnt=100 after 100 further bits.
- Locked, then invert 3 isolated bits (WIN_LEN=256, THRESH=32) -> err_cnt=3, three single-cycle err_pulse; locked stays 1.
- Locked, then a burst of 32 inverted bits within one window -> locked drops after the 32nd error; err_cnt=32; relock after 12 clean bits; bit_cnt continues from its prior value.
- Feed all-zero bits -> stays in HUNT indefinitely; locked=0; counters remain 0.
- Assert reset low mid-LOCK -> locked, err_pulse and counters read 0 immediately; relock from scratch after release.
- LFSR_CHK_CLR_EN defined: pulse clr while locked with err_cnt=5 -> err_cnt=0 and bit_cnt=0 next clk; locked stays 1.
